// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: frame FSM states and the default frame length.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection on the synchronized level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   warm;

    // Edges are suppressed until the chain holds real samples, so an input already
    // sitting away from RESET_VAL when reset releases does not look like a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            warm  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            warm  <= {warm[STAGES-1:0], 1'b1};
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = warm[STAGES] & level & ~prev;
    assign fall  = warm[STAGES] & ~level & prev;

endmodule

// File: rtl/spi_target.sv
// SPI target (slave) with CPOL/CPHA/bit-order selection, a one-word TX holding register
// and a one-word RX output register, all running on the system clock.
module spi_target
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  msb_first,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  tx_underrun,
    output logic                  rx_overrun,
    output logic                  frame_abort,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

    spi_state_t            state;
    logic                  sck_s, sck_rise, sck_fall;
    logic                  cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                  mosi_s;
    logic                  cpol_l, cpha_l, msb_l;
    logic                  skip_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift, hold, rx_shift, rx_next;
    logic                  hold_full;
    logic                  sck_edge, lead_edge, trail_edge;
    logic                  active, sample_edge, shift_edge, frame_complete;
    logic                  frame_start, tx_take;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(spi_sck),
        .level(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_chain <= '0;
        else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
    end

    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // Leading edge = sck just moved away from the latched idle level.
    assign sck_edge       = sck_rise | sck_fall;
    assign lead_edge      = sck_edge & (sck_s != cpol_l);
    assign trail_edge     = sck_edge & (sck_s == cpol_l);
    assign active         = (state == SHIFT) & ~cs_s & ~cs_rise;
    assign sample_edge    = active & (cpha_l ? trail_edge : lead_edge);
    assign shift_edge     = active & (cpha_l ? lead_edge : trail_edge);
    assign frame_complete = sample_edge & (bit_cnt == LAST_BIT);
    assign frame_start    = (state == IDLE) & cs_fall;
    assign tx_take        = tx_valid & tx_ready;
    assign rx_next        = msb_l ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                  : {mosi_s, rx_shift[DATA_WIDTH-1:1]};

    assign tx_ready    = ~hold_full;
    assign spi_miso_oe = (state != IDLE);
    assign spi_miso    = spi_miso_oe & (msb_l ? tx_shift[DATA_WIDTH-1] : tx_shift[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            msb_l       <= 1'b0;
            skip_shift  <= 1'b0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            frame_done  <= 1'b0;

            // A word offered in the frame-start cycle goes straight into the shifter.
            if (tx_take && !frame_start) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state      <= SHIFT;
                        cpol_l     <= cpol;
                        cpha_l     <= cpha;
                        msb_l      <= msb_first;
                        skip_shift <= cpha;
                        bit_cnt    <= '0;
                        rx_shift   <= '0;
                        if (hold_full) begin
                            tx_shift  <= hold;
                            hold_full <= 1'b0;
                        end else if (tx_valid) begin
                            tx_shift <= tx_data;
                        end else begin
                            tx_shift    <= '0;
                            tx_underrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        frame_abort <= 1'b1;
                        rx_shift    <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + 1'b1;
                            if (frame_complete) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (skip_shift) skip_shift <= 1'b0;
                            else            tx_shift   <= msb_l ? (tx_shift << 1) : (tx_shift >> 1);
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A consumer read in the completion cycle frees the slot for the new word.
            if (frame_complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
